workout_interval_timer: RTL
===========================

# workout_interval_timer

Countdown timer controller that sequences the single interval timer shared by the workout and rest phases of the fitness controller. It loads the phase duration on every phase entry and counts down on a prescaled 1 s tick. It supports pause and skip, and returns a one-cycle `time_done` pulse to the workout state machine. It also drives the display with binary remaining seconds plus a minutes/seconds BCD breakdown.

## Interface
- `WORK_SEC`, default 30: workout duration in seconds, range 0..255.
- `REST_SEC`, default 10: rest duration in seconds, range 0..255.
- `DIV`, default 1: clk cycles per 1 s tick, ≥1; 1 when clk is the 1 Hz clock.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_timer`  in  1  level; the timer is enabled while high.
- `phase`  in  2  current controller state: 01 = workout, 10 = rest; other values mean no phase.
- `skip`  in  1  abandon the current interval.
- `pause`  in  1  level; freezes the countdown while high.
- `time_done`  out  1  one-cycle pulse when the interval expires.
- `remaining`  out  8  seconds left, binary.
- `minutes`  out  3  remaining / 60, range 0..4.
- `sec_tens`  out  3  tens digit of remaining % 60, range 0..5.
- `sec_ones`  out  4  ones digit of remaining % 60, range 0..9.
- `running`  out  1  high in RUN only.
- `warn`  out  1  last-seconds warning pulse (see Configuration).

## Operation
- States:
  - IDLE
  - LOAD
  - RUN
  - PAUSE
  - DONE
  - HOLD
- `phase` is latched into `cur_phase` on entry to LOAD.
- Transition priority each edge, highest first:
  1. `start_timer` = 0 in any non-IDLE state → IDLE.
  2. `skip` = 1 in RUN or PAUSE → HOLD. `remaining` is cleared and `time_done` is not pulsed; the workout FSM handles skip itself.
  3. `phase` ≠ `cur_phase` with `phase` ∈ {01, 10}, in RUN, PAUSE or HOLD → LOAD (re-arm).
  4. Expiry or pause, per the state list below.
- IDLE:
  - Outputs are held at 0.
  - → LOAD when `start_timer` = 1 and `phase` ∈ {01, 10}.
- LOAD (one cycle):
  - `remaining` = `WORK_SEC` or `REST_SEC` according to `cur_phase`.
  - The BCD fields are loaded with the matching constant breakdown.
  - The prescaler is cleared.
  - → RUN, or → DONE if the loaded duration is 0.
- RUN:
  - The prescaler counts 0..DIV-1; a tick occurs when it wraps.
  - On a tick, `remaining` decrements and the BCD fields decrement with borrow: `sec_ones` 0→9 borrows from `sec_tens`, and `sec_tens` 0→5 borrows from `minutes`.
  - A tick with `remaining` = 1 → DONE, with `remaining` = 0.
  - `pause` = 1 with no tick this cycle → PAUSE.
  - A tick takes precedence over pause in the same cycle.
- PAUSE:
  - The prescaler and counts are frozen.
  - `pause` = 0 → RUN, and the prescaler resumes from its frozen value.
- DONE: `time_done` = 1 for exactly this one cycle, then → HOLD.
- HOLD:
  - `remaining` = 0.
  - Waits for a phase change (→ LOAD) or `start_timer` = 0 (→ IDLE).
- Invariant: `minutes`*60 + `sec_tens`*10 + `sec_ones` == `remaining` at all times. The count never underflows.

## Timing
- All outputs are registered.
- Reset value of every output is 0. Reset also sends the state to IDLE and clears the prescaler and `cur_phase`.
- `reset_n` asserted mid-interval: outputs go to 0 immediately (asynchronous). After release, the block waits in IDLE for `start_timer`.
- Entry latency:
  - Trigger sampled at edge N → LOAD.
  - Edge N+1 → RUN with `remaining` = duration.
- Countdown:
  - First decrement at edge N+1+DIV.
  - `time_done` is high during the cycle after edge N+1+duration×DIV.
- `skip` or a phase change takes effect at the sampling edge, one-cycle latency to the new state.
- `phase` changing while in LOAD is ignored until RUN.
- `start_timer` and `phase` changing together: the IDLE rule has priority.

## Configuration
- `WORKOUT_TIMER_WARN_EN` defined:
  - `warn` pulses for one cycle on each RUN tick that leaves `remaining` at 3, 2 or 1.
  - Suppressed in REST when `REST_SEC` < 4.
- `WORKOUT_TIMER_WARN_EN` undefined:
  - `warn` is tied to 0 and no warning logic is built.
  - The port is always present.

## Test plan
- DIV=1, WORK_SEC=3; `start_timer`=1, `phase`=01 at edge 0 → `remaining` 3,2,1,0 at edges 1–4; `time_done` high only in the cycle after edge 4; HOLD follows.
- WORK_SEC=75 load → `minutes`=1, `sec_tens`=1, `sec_ones`=5; one tick later 1,1,4; at 60 → 1,0,0; next tick 0,5,9.
- DIV=4; `pause`=1 for 10 cycles mid-RUN → `remaining` unchanged throughout; after `pause`=0, the next decrement occurs after the residual prescaler count.
- `skip`=1 at `remaining`=20 → HOLD, `remaining`=0, no `time_done`; then `phase` 01→10 → REST_SEC loaded two edges later.
- REST_SEC=0 with `phase`=10 → LOAD → DONE; `time_done` pulse two cycles after the trigger.
- `reset_n`=0 mid-RUN at `remaining`=17 → all outputs 0 immediately; with WARN_EN, `warn` pulses exactly 3 times per interval ≥4 s.

Source files
------------

// File: rtl/workout_interval_timer_if.sv
// workout_interval_timer_if: controller-to-timer bundle (controls in, countdown/status out)
interface workout_interval_timer_if;
  logic       start_timer;
  logic [1:0] phase;
  logic       skip;
  logic       pause;
  logic       time_done;
  logic [7:0] remaining;
  logic [2:0] minutes;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       warn;
  modport master (
    output start_timer, phase, skip, pause,
    input  time_done, remaining, minutes, sec_tens, sec_ones, running, warn
  );
  modport slave (
    input  start_timer, phase, skip, pause,
    output time_done, remaining, minutes, sec_tens, sec_ones, running, warn
  );
endinterface

// File: rtl/workout_interval_timer.sv
// workout_interval_timer: shared workout/rest countdown with pause, skip, done pulse and m:ss BCD display
// Ports: clk, reset_n (async, active low); bus (slave) carries start_timer/phase/skip/pause in and
// time_done/remaining/minutes/sec_tens/sec_ones/running/warn out, all outputs registered.
// Optional: define WORKOUT_TIMER_WARN_EN to build the last-three-seconds warn pulse (else warn = 0).
module workout_interval_timer #(
  parameter int WORK_SEC = 30,
  parameter int REST_SEC = 10,
  parameter int DIV      = 1
) (
  input logic clk,
  input logic reset_n,
  workout_interval_timer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE, HOLD} state_t;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  state_t state_q, state_d;
  logic [1:0] cur_phase_q, cur_phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] rem_q, rem_d;
  logic [2:0] min_q, min_d, tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic done_q, done_d, run_q, run_d;
  logic phase_ok, phase_chg, tick, dec, is_work;
  logic [7:0] dur;
  logic [2:0] dur_min, dur_tens;
  logic [3:0] dur_ones;
  assign phase_ok  = bus.phase == 2'b01 || bus.phase == 2'b10;
  assign phase_chg = phase_ok && bus.phase != cur_phase_q;
  assign tick      = state_q == RUN && presc_q == PW'(DIV - 1);
  assign is_work   = cur_phase_q == 2'b01;
  assign dur       = is_work ? 8'(WORK_SEC) : 8'(REST_SEC);
  assign dur_min   = is_work ? 3'(WORK_SEC / 60) : 3'(REST_SEC / 60);
  assign dur_tens  = is_work ? 3'((WORK_SEC % 60) / 10) : 3'((REST_SEC % 60) / 10);
  assign dur_ones  = is_work ? 4'(WORK_SEC % 10) : 4'(REST_SEC % 10);
  // a tick only counts down when the FSM stays in the interval (skip/re-arm/stop win)
  assign dec       = tick && (state_d == RUN || state_d == DONE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_phase_q <= '0;
      presc_q     <= '0;
      rem_q       <= '0;
      min_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
      presc_q     <= presc_d;
      rem_q       <= rem_d;
      min_q       <= min_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      done_q      <= done_d;
      run_q       <= run_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = phase_ok ? LOAD : IDLE;
      LOAD:    state_d = dur == 8'd0 ? DONE : RUN;
      RUN:     state_d = bus.skip ? HOLD : phase_chg ? LOAD : (tick && rem_q == 8'd1) ? DONE :
                         (bus.pause && !tick) ? PAUSE : RUN;
      PAUSE:   state_d = bus.skip ? HOLD : phase_chg ? LOAD : bus.pause ? PAUSE : RUN;
      DONE:    state_d = HOLD;
      HOLD:    state_d = phase_chg ? LOAD : HOLD;
      default: state_d = IDLE;
    endcase
    if (!bus.start_timer) state_d = IDLE;
  end
  always_comb begin
    cur_phase_d = state_d == LOAD ? bus.phase : cur_phase_q;
    // the RUN cycle that enters PAUSE still counts; PAUSE keeps the residual count
    presc_d = state_q == RUN ? (tick ? '0 : presc_q + 1'b1) : state_q == PAUSE ? presc_q : '0;
    rem_d   = rem_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (state_d == IDLE || state_d == HOLD) begin
      rem_d  = '0;
      min_d  = '0;
      tens_d = '0;
      ones_d = '0;
    end else if (state_q == LOAD) begin
      rem_d  = dur;
      min_d  = dur_min;
      tens_d = dur_tens;
      ones_d = dur_ones;
    end else if (dec) begin
      rem_d  = rem_q - 8'd1;
      ones_d = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
      tens_d = ones_q != 4'd0 ? tens_q : tens_q == 3'd0 ? 3'd5 : tens_q - 3'd1;
      min_d  = (ones_q == 4'd0 && tens_q == 3'd0) ? min_q - 3'd1 : min_q;
    end
    done_d = state_d == DONE;
    run_d  = state_d == RUN;
  end
`ifdef WORKOUT_TIMER_WARN_EN
  logic warn_q, warn_d;
  assign warn_d = dec && rem_q >= 8'd2 && rem_q <= 8'd4 && !(cur_phase_q == 2'b10 && REST_SEC < 4);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warn_q <= 1'b0;
    else warn_q <= warn_d;
  end
  assign bus.warn = warn_q;
`else
  assign bus.warn = 1'b0;
`endif
  assign bus.time_done = done_q;
  assign bus.remaining = rem_q;
  assign bus.minutes   = min_q;
  assign bus.sec_tens  = tens_q;
  assign bus.sec_ones  = ones_q;
  assign bus.running   = run_q;
endmodule
